// File: rtl/core_pkg.sv
// Shared opcode constants, FSM encoding and decode helpers for the 4-bit core.
// Used by the fetch/decode sequencer and by the ALU (same OPR constants).
package core_pkg;

   localparam int PC_W_DEF = 12;

   localparam logic [3:0] OPR_NOP     = 4'h0;
   localparam logic [3:0] OPR_JCN     = 4'h1;
   localparam logic [3:0] OPR_FIM_SRC = 4'h2;
   localparam logic [3:0] OPR_JUN     = 4'h4;
   localparam logic [3:0] OPR_ADD     = 4'h8;
   localparam logic [3:0] OPR_SUB     = 4'h9;
   localparam logic [3:0] OPR_LD      = 4'hA;
   localparam logic [3:0] OPR_XCH     = 4'hB;
   localparam logic [3:0] OPR_LDM     = 4'hD;

   // ALU op that passes the selected opa to the result
   localparam logic [3:0] ALU_PASS = 4'hD;

   typedef enum logic [1:0] {
      ST_FETCH1,
      ST_DECODE,
      ST_FETCH2,
      ST_EXEC
   } state_e;

   // OPR 2 with ir[0]=0 is FIM; ir[0]=1 (SRC) is not supported
   function automatic logic is_fim(input logic [7:0] b);
      return (b[7:4] == OPR_FIM_SRC) && !b[0];
   endfunction

   function automatic logic is_two_byte(input logic [7:0] b);
      return (b[7:4] == OPR_JCN) || (b[7:4] == OPR_JUN) || is_fim(b);
   endfunction

   function automatic logic is_legal(input logic [7:0] b);
      logic ok;
      case (b[7:4])
         OPR_NOP, OPR_JCN, OPR_JUN,
         OPR_ADD, OPR_SUB, OPR_LD,
         OPR_XCH, OPR_LDM:  ok = 1'b1;
         OPR_FIM_SRC:       ok = !b[0];
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/fetch_decode_seq_if.sv
// Sequencer bus: ROM fetch handshake, JCN condition inputs, ALU/regfile controls.
// master = sequencer side, slave = ROM/ALU/regfile side.
interface fetch_decode_seq_if
   import core_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic            rom_rd;
   logic [PC_W-1:0] rom_addr;
   logic [7:0]      rom_data;
   logic            rom_ack;
   logic            acc_zero;
   logic            carry_flag;
   logic            test_n;
   logic [3:0]      alu_op;
   logic [3:0]      opa;
   logic            opa_sel;
   logic            acc_we;
   logic            carry_we;
   logic [3:0]      reg_addr;
   logic            reg_we;
   logic [7:0]      reg_wdata;
   logic            illegal;

   modport master (
      output rom_rd, rom_addr,
      input  rom_data, rom_ack,
      input  acc_zero, carry_flag, test_n,
      output alu_op, opa, opa_sel, acc_we, carry_we,
      output reg_addr, reg_we, reg_wdata, illegal
   );

   modport slave (
      input  rom_rd, rom_addr,
      output rom_data, rom_ack,
      output acc_zero, carry_flag, test_n,
      input  alu_op, opa, opa_sel, acc_we, carry_we,
      input  reg_addr, reg_we, reg_wdata, illegal
   );

endinterface

// File: rtl/fetch_decode_seq_jcn_cond.sv
// JCN condition evaluator: opa_i = JCN condition nibble, test_n_i/carry_i/acc_zero_i
// = live flags; take_o = 1 when the jump is taken (condition, optionally inverted).
module jcn_cond (
   input  logic [3:0] opa_i,
   input  logic       test_n_i,
   input  logic       carry_i,
   input  logic       acc_zero_i,
   output logic       take_o
);

   logic cond;

   assign cond = (opa_i[0] & ~test_n_i) |
                 (opa_i[1] & carry_i)   |
                 (opa_i[2] & acc_zero_i);

   // opa[3] inverts the sense, so 4'h8 always jumps
   assign take_o = cond ^ opa_i[3];

endmodule

// File: rtl/fetch_decode_seq.sv
// Fetch/decode sequencer: fetches 1/2-byte instructions, keeps PC, drives one EXEC cycle.
// Ports: clk, rst (sync, active high), bus (master: ROM handshake, flags in, ALU/reg controls out).
module fetch_decode_seq
   import core_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst,
   fetch_decode_seq_if.master bus
);

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [7:0]      ir_q;
   logic [7:0]      b2_q;

   logic [3:0] alu_op_q, opa_q, reg_addr_q;
   logic       opa_sel_q, acc_we_q, carry_we_q, reg_we_q, illegal_q;
   logic [7:0] reg_wdata_q;

   logic [3:0] alu_op_d, reg_addr_d;
   logic       opa_sel_d, acc_we_d, carry_we_d, reg_we_d;
   logic [7:0] reg_wdata_d;

   logic [3:0] opr;
   logic       fetch_st;
   logic       ack;
   logic       jcn_take;

   assign opr      = ir_q[7:4];
   assign fetch_st = (state_q == ST_FETCH1) || (state_q == ST_FETCH2);

   // rst gates the request so a reset mid-fetch drops it at once
   assign bus.rom_rd   = fetch_st & ~rst;
   assign bus.rom_addr = bus.rom_rd ? pc_q : '0;
   assign ack          = bus.rom_rd & bus.rom_ack;

   assign bus.alu_op    = alu_op_q;
   assign bus.opa       = opa_q;
   assign bus.opa_sel   = opa_sel_q;
   assign bus.acc_we    = acc_we_q;
   assign bus.carry_we  = carry_we_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.illegal   = illegal_q;

   jcn_cond u_jcn (
      .opa_i      (ir_q[3:0]),
      .test_n_i   (bus.test_n),
      .carry_i    (bus.carry_flag),
      .acc_zero_i (bus.acc_zero),
      .take_o     (jcn_take)
   );

   // EXEC controls; FIM data is byte2 straight off the ROM bus
   always_comb begin
      alu_op_d    = OPR_NOP;
      opa_sel_d   = 1'b0;
      acc_we_d    = 1'b0;
      carry_we_d  = 1'b0;
      reg_addr_d  = '0;
      reg_we_d    = 1'b0;
      reg_wdata_d = '0;
      unique case (1'b1)
         (opr == OPR_ADD) || (opr == OPR_SUB): begin
            alu_op_d   = opr;
            opa_sel_d  = 1'b1;
            reg_addr_d = ir_q[3:0];
            acc_we_d   = 1'b1;
            carry_we_d = 1'b1;
         end
         opr == OPR_LD: begin
            alu_op_d   = ALU_PASS;
            opa_sel_d  = 1'b1;
            reg_addr_d = ir_q[3:0];
            acc_we_d   = 1'b1;
         end
         opr == OPR_XCH: begin
            alu_op_d   = ALU_PASS;
            opa_sel_d  = 1'b1;
            reg_addr_d = ir_q[3:0];
            acc_we_d   = 1'b1;
            reg_we_d   = 1'b1;
         end
         opr == OPR_LDM: begin
            alu_op_d = ALU_PASS;
            acc_we_d = 1'b1;
         end
         is_fim(ir_q): begin
            reg_addr_d  = {ir_q[3:1], 1'b0};
            reg_wdata_d = bus.rom_data;
            reg_we_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH1;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         b2_q        <= '0;
         alu_op_q    <= OPR_NOP;
         opa_q       <= '0;
         opa_sel_q   <= 1'b0;
         acc_we_q    <= 1'b0;
         carry_we_q  <= 1'b0;
         reg_addr_q  <= '0;
         reg_we_q    <= 1'b0;
         reg_wdata_q <= '0;
         illegal_q   <= 1'b0;
      end else begin
         alu_op_q    <= OPR_NOP;
         opa_q       <= '0;
         opa_sel_q   <= 1'b0;
         acc_we_q    <= 1'b0;
         carry_we_q  <= 1'b0;
         reg_addr_q  <= '0;
         reg_we_q    <= 1'b0;
         reg_wdata_q <= '0;
         illegal_q   <= 1'b0;
         unique case (state_q)
            ST_FETCH1: begin
               if (ack) begin
                  ir_q      <= bus.rom_data;
                  pc_q      <= pc_q + PC_W'(1);
                  illegal_q <= ~is_legal(bus.rom_data);
                  state_q   <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (is_two_byte(ir_q)) begin
                  state_q <= ST_FETCH2;
               end else begin
                  alu_op_q   <= alu_op_d;
                  opa_q      <= ir_q[3:0];
                  opa_sel_q  <= opa_sel_d;
                  acc_we_q   <= acc_we_d;
                  carry_we_q <= carry_we_d;
                  reg_addr_q <= reg_addr_d;
                  reg_we_q   <= reg_we_d;
                  state_q    <= ST_EXEC;
               end
            end
            ST_FETCH2: begin
               if (ack) begin
                  b2_q        <= bus.rom_data;
                  pc_q        <= pc_q + PC_W'(1);
                  opa_q       <= ir_q[3:0];
                  reg_addr_q  <= reg_addr_d;
                  reg_we_q    <= reg_we_d;
                  reg_wdata_q <= reg_wdata_d;
                  state_q     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (opr == OPR_JUN)
                  pc_q <= PC_W'({ir_q[3:0], b2_q});
               else if (opr == OPR_JCN && jcn_take)
                  pc_q <= {pc_q[PC_W-1:8], b2_q};
               state_q <= ST_FETCH1;
            end
            default: state_q <= ST_FETCH1;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed bench for fetch_decode_seq: ROM model with programmable ack delay.
// Walks LDM/ADD, JUN, FIM, illegal, JCN paths, PC wrap and reset mid-fetch.
module tb_fetch_decode_seq;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [7:0] rom [0:4095];
   logic       force_ack = 1'b1;
   int         ack_dly   = 0;
   int         wcnt      = 0;
   logic       ack_r     = 1'b0;
   logic [7:0] data_r    = 8'h00;
   logic       az        = 1'b0;
   logic       cf        = 1'b0;
   logic       tn        = 1'b1;

   int checks = 0;
   int errors = 0;

   fetch_decode_seq_if #(.PC_W(12)) bus ();

   assign bus.rom_ack    = ack_r;
   assign bus.rom_data   = data_r;
   assign bus.acc_zero   = az;
   assign bus.carry_flag = cf;
   assign bus.test_n     = tn;

   fetch_decode_seq #(.PC_W(12), .RESET_PC(12'h000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // ROM: ack after ack_dly wait cycles of a held request
   always @(posedge clk) begin
      #2;
      if (force_ack) begin
         ack_r  = 1'b1;
         data_r = rom[bus.rom_addr];
      end else if (bus.rom_rd) begin
         if (wcnt >= ack_dly) begin
            ack_r  = 1'b1;
            data_r = rom[bus.rom_addr];
            wcnt   = 0;
         end else begin
            ack_r = 1'b0;
            wcnt  = wcnt + 1;
         end
      end else begin
         ack_r = 1'b0;
         wcnt  = 0;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[12'h000] = 8'hD5;
      rom[12'h001] = 8'h85;
      rom[12'h002] = 8'h44;
      rom[12'h003] = 8'hA3;
      rom[12'h4A3] = 8'h26;
      rom[12'h4A4] = 8'h7E;
      rom[12'h4A5] = 8'h3E;
      rom[12'h4A6] = 8'h40;
      rom[12'h4A7] = 8'h10;
      rom[12'h010] = 8'h14;
      rom[12'h011] = 8'h20;
      rom[12'h012] = 8'h1C;
      rom[12'h013] = 8'h20;
      rom[12'h020] = 8'h40;
      rom[12'h021] = 8'h10;
      rom[12'hFFF] = 8'h45;

      tick(2);
      check("rst_rd", bus.rom_rd, 0);
      check("rst_alu", bus.alu_op, 0);
      check("rst_accwe", bus.acc_we, 0);
      check("rst_cywe", bus.carry_we, 0);
      check("rst_regwe", bus.reg_we, 0);
      check("rst_ill", bus.illegal, 0);

      rst = 1'b0;
      force_ack = 1'b0;
      #1;
      check("c1_rd", bus.rom_rd, 1);
      check("c1_addr", bus.rom_addr, 12'h000);
      check("c1_accwe", bus.acc_we, 0);

      tick(2);
      check("ldm_alu", bus.alu_op, 4'hD);
      check("ldm_opa", bus.opa, 4'h5);
      check("ldm_sel", bus.opa_sel, 0);
      check("ldm_accwe", bus.acc_we, 1);
      check("ldm_cywe", bus.carry_we, 0);

      tick(3);
      check("add_alu", bus.alu_op, 4'h8);
      check("add_ra", bus.reg_addr, 4'h5);
      check("add_sel", bus.opa_sel, 1);
      check("add_accwe", bus.acc_we, 1);
      check("add_cywe", bus.carry_we, 1);

      tick(3);
      check("jun_f2_rd", bus.rom_rd, 1);
      check("jun_f2_addr", bus.rom_addr, 12'h003);
      tick(1);
      check("jun_accwe", bus.acc_we, 0);
      check("jun_regwe", bus.reg_we, 0);
      tick(1);
      check("jun_addr", bus.rom_addr, 12'h4A3);

      tick(3);
      check("fim_regwe", bus.reg_we, 1);
      check("fim_ra", bus.reg_addr, 4'h6);
      check("fim_wd", bus.reg_wdata, 8'h7E);
      check("fim_accwe", bus.acc_we, 0);
      tick(1);
      check("fim_regwe_off", bus.reg_we, 0);

      tick(1);
      check("ill_pulse", bus.illegal, 1);
      tick(1);
      check("ill_off", bus.illegal, 0);
      check("ill_alu", bus.alu_op, 0);
      check("ill_accwe", bus.acc_we, 0);
      check("ill_regwe", bus.reg_we, 0);

      tick(5);
      check("jun010_addr", bus.rom_addr, 12'h010);
      tick(4);
      check("jcn_nt_addr", bus.rom_addr, 12'h012);
      tick(4);
      check("jcn_inv_addr", bus.rom_addr, 12'h020);
      tick(4);
      check("jun010b_addr", bus.rom_addr, 12'h010);
      az = 1'b1;
      rom[12'h020] = 8'h4F;
      rom[12'h021] = 8'hFF;
      tick(4);
      check("jcn_tk_addr", bus.rom_addr, 12'h020);
      tick(4);
      check("junfff_addr", bus.rom_addr, 12'hFFF);

      tick(1);
      ack_dly = 3;
      tick(1);
      check("wrap_rd", bus.rom_rd, 1);
      check("wrap_addr", bus.rom_addr, 12'h000);
      tick(1);
      check("wait_rd", bus.rom_rd, 1);
      check("wait_addr", bus.rom_addr, 12'h000);
      tick(1);
      rst = 1'b1;
      ack_dly = 0;
      #1;
      check("midrst_rd", bus.rom_rd, 0);
      tick(1);
      rst = 1'b0;
      #1;
      check("post_rd", bus.rom_rd, 1);
      check("post_addr", bus.rom_addr, 12'h000);
      tick(2);
      check("post_ldm_alu", bus.alu_op, 4'hD);
      check("post_ldm_accwe", bus.acc_we, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
